lsu: RTL and testbench
======================

# lsu

Load/store unit in CPU_EXU, directly downstream of the ALU. Takes one ALU result per transfer: either a memory op (address, load/store flags, store data) or a plain register result. Memory ops run as a single outstanding request on the data-memory bus. Aligned load data is sign- or zero-extended, then everything is registered toward write-back.

## Interface
Parameters:
- MEM_TIMEOUT, 255: cycles an issued request may wait for mem_ready before it is aborted with bus_err; valid range 1..255.

Ports (`XLEN` = 32, `XREG_ADDRWIDTH` = 5, both from config.v):
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  LSU can accept; transfer when in_valid && in_ready
- addr_in  in  XLEN  ALU rd_out: effective address for memory ops, register result otherwise
- load_flag_in  in  5  `LOAD_B/H/W/BU/HU` or `NO_LOAD`
- store_flag_in  in  4  `STORE_B/H/W` or zero
- store_data_in  in  XLEN  rs2 value
- rd_en_in  in  1; rd_addr_in  in  XREG_ADDRWIDTH
- mem_req  out  1; mem_we  out  1; mem_addr  out  XLEN  word-aligned ({addr[31:2],2'b00})
- mem_wstrb  out  4; mem_wdata  out  XLEN
- mem_ready  in  1  completion; mem_rdata valid in the same cycle
- mem_rdata  in  XLEN
- wb_valid  out  1; wb_en  out  1; wb_addr  out  XREG_ADDRWIDTH; wb_data  out  XLEN
- misalign  out  1  one-cycle pulse; misalign_addr  out  XLEN
- bus_err  out  1  one-cycle pulse on timeout

## Operation
- FSM states are IDLE and BUSY. in_ready = (state == IDLE).
- In IDLE, a transfer is classified by its flags:
  - Non-memory (both flags zero, or any unlisted encoding): next cycle wb_valid=1, wb_data=addr_in, wb_en=rd_en_in, wb_addr=rd_addr_in. Stay IDLE.
  - Both a load and a store flag set: treated as a load.
  - Misaligned (H/HU with addr[0]=1; W with addr[1:0]≠0): no bus request. Next cycle misalign=1 and misalign_addr=addr_in; wb_valid stays 0. Stay IDLE.
  - Aligned memory op: latch the op and go to BUSY. mem_req=1 from the next cycle.
- Store lane encoding:
  - Byte: wstrb=4'b0001<<addr[1:0], wdata={4{d[7:0]}}.
  - Half: wstrb=4'b0011<<addr[1:0], wdata={2{d[15:0]}}.
  - Word: wstrb=4'b1111, wdata=d.
  - mem_we=1 for stores.
- Load requests: mem_we=0, mem_wstrb=0.
- In BUSY:
  - mem_req and all mem_* outputs are held stable until mem_ready.
  - On mem_ready, return to IDLE. Next cycle wb_valid=1.
  - Loads: wb_data = field of (mem_rdata >> 8*addr[1:0]), sign-extended for B/H, zero-extended for BU/HU/W.
  - Stores: wb_en=0.
- wb_en is forced to 0 when wb_addr==0.
- Timeout: a counter clears on entering BUSY and increments each BUSY cycle without mem_ready. When it reaches MEM_TIMEOUT, drop mem_req, pulse bus_err for one cycle, return to IDLE; wb_valid stays 0. If mem_ready arrives in the same cycle the counter reaches MEM_TIMEOUT, completion wins.
- mem_ready in IDLE is ignored.

## Timing
- Reset values (state, then all outputs):
  - state=IDLE; in_ready=1.
  - mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
  - wb_valid=0, wb_en=0, wb_addr=0, wb_data=0.
  - misalign=0, misalign_addr=0, bus_err=0.
- Reset mid-BUSY: mem_req drops at the reset edge and the pending op is discarded with no write-back. The memory side must tolerate an abandoned request.
- Latency:
  - Non-memory or misaligned: 1 cycle.
  - Memory op, counted from the accept edge: mem_req at +1, wb_valid at the edge after mem_ready, so 2 cycles minimum with zero-wait memory.
- Throughput: non-memory ops 1 per cycle. A memory op blocks the next transfer until the cycle in which its wb_valid is high; in_ready is high again in that cycle.
- wb_valid, misalign and bus_err are one-cycle pulses. There is no back-pressure from write-back.

## Structure
- Flag encodings (`LOAD_*`, `STORE_*`, `NO_LOAD`), `XLEN`, `XREG_ADDRWIDTH` come from the shared config.v. Add `LSU_IDLE` and `LSU_BUSY` state macros there.
- One sub-module, lsu_load_align: combinational rdata shift plus sign/zero extension, taking load_flag and addr[1:0].

## Test plan
- Non-memory: in_valid, addr_in=0x1234, rd_addr=5, rd_en=1, flags zero -> next cycle wb_valid=1, wb_data=0x1234, wb_en=1, wb_addr=5.
- LOAD_B at 0x103, mem_rdata=0x80FF_0000, mem_ready in the first request cycle -> mem_addr=0x100, wb_data=0xFFFF_FF80. The same case with LOAD_BU -> wb_data=0x0000_0080.
- STORE_H at 0x202, data 0xDEAD_BEEF, mem_ready after 3 wait cycles -> mem_wstrb=4'b1100, mem_wdata=0xBEEF_BEEF. in_ready=0 until completion, wb_en=0.
- LOAD_W at 0x101 -> no mem_req, misalign=1 for 1 cycle with misalign_addr=0x101, wb_valid=0.
- MEM_TIMEOUT=4, LOAD_W with mem_ready never asserted -> bus_err pulses after 4 BUSY cycles, mem_req drops, back in IDLE.
- rst asserted in the second BUSY cycle, then a stray mem_ready 2 cycles later -> all outputs at reset values, no wb_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: datapath widths, load/store flag
// encodings, FSM state type and flag classification helpers.
package lsu_pkg;

  localparam int XLEN           = 32;
  localparam int XREG_ADDRWIDTH = 5;

  localparam logic [4:0] NO_LOAD = 5'b00000;
  localparam logic [4:0] LOAD_B  = 5'b00001;
  localparam logic [4:0] LOAD_H  = 5'b00010;
  localparam logic [4:0] LOAD_W  = 5'b00100;
  localparam logic [4:0] LOAD_BU = 5'b01000;
  localparam logic [4:0] LOAD_HU = 5'b10000;

  localparam logic [3:0] NO_STORE = 4'b0000;
  localparam logic [3:0] STORE_B  = 4'b0001;
  localparam logic [3:0] STORE_H  = 4'b0010;
  localparam logic [3:0] STORE_W  = 4'b0100;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_e;

  // Only the listed encodings count as memory ops; anything else is a plain result.
  function automatic logic is_load_flag(input logic [4:0] f);
    return (f == LOAD_B) || (f == LOAD_H) || (f == LOAD_W) ||
           (f == LOAD_BU) || (f == LOAD_HU);
  endfunction

  function automatic logic is_store_flag(input logic [3:0] f);
    return (f == STORE_B) || (f == STORE_H) || (f == STORE_W);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// ALU-side transfer, data-memory bus and write-back signals of the LSU.
interface lsu_if;
  import lsu_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [XLEN-1:0]           addr_in;
  logic [4:0]                load_flag_in;
  logic [3:0]                store_flag_in;
  logic [XLEN-1:0]           store_data_in;
  logic                      rd_en_in;
  logic [XREG_ADDRWIDTH-1:0] rd_addr_in;

  logic                      mem_req;
  logic                      mem_we;
  logic [XLEN-1:0]           mem_addr;
  logic [3:0]                mem_wstrb;
  logic [XLEN-1:0]           mem_wdata;
  logic                      mem_ready;
  logic [XLEN-1:0]           mem_rdata;

  logic                      wb_valid;
  logic                      wb_en;
  logic [XREG_ADDRWIDTH-1:0] wb_addr;
  logic [XLEN-1:0]           wb_data;

  logic                      misalign;
  logic [XLEN-1:0]           misalign_addr;
  logic                      bus_err;

  // master: ALU/memory/write-back environment; slave: the LSU itself
  modport master (
    output in_valid, addr_in, load_flag_in, store_flag_in, store_data_in,
           rd_en_in, rd_addr_in, mem_ready, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
           wb_valid, wb_en, wb_addr, wb_data, misalign, misalign_addr, bus_err
  );

  modport slave (
    input  in_valid, addr_in, load_flag_in, store_flag_in, store_data_in,
           rd_en_in, rd_addr_in, mem_ready, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
           wb_valid, wb_en, wb_addr, wb_data, misalign, misalign_addr, bus_err
  );

endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a memory read word and
// sign- or zero-extends it to XLEN.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [4:0]      load_flag,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (load_flag)
      LOAD_B:  data = {{24{shifted[7]}}, shifted[7:0]};
      LOAD_H:  data = {{16{shifted[15]}}, shifted[15:0]};
      LOAD_BU: data = {24'h0, shifted[7:0]};
      LOAD_HU: data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: classifies ALU results, runs one outstanding data-memory
// request at a time with a timeout, and registers results toward write-back.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  lsu_state_e                state;
  logic [7:0]                cnt;
  logic                      ld_q;
  logic [4:0]                ld_flag_q;
  logic [1:0]                off_q;
  logic                      rd_en_q;
  logic [XREG_ADDRWIDTH-1:0] rd_addr_q;

  logic            is_ld, is_st, half, word, mis;
  logic [3:0]      strb;
  logic [XLEN-1:0] wdat, ld_data;

  lsu_load_align u_align (
    .rdata     (bus.mem_rdata),
    .load_flag (ld_flag_q),
    .offset    (off_q),
    .data      (ld_data)
  );

  assign bus.in_ready = (state == LSU_IDLE);

  // A load flag takes precedence when both a load and a store flag are set.
  always_comb begin
    is_ld = is_load_flag(bus.load_flag_in);
    is_st = !is_ld && is_store_flag(bus.store_flag_in);
    half  = is_ld ? (bus.load_flag_in == LOAD_H || bus.load_flag_in == LOAD_HU)
                  : (is_st && bus.store_flag_in == STORE_H);
    word  = is_ld ? (bus.load_flag_in == LOAD_W)
                  : (is_st && bus.store_flag_in == STORE_W);
    mis   = (half && bus.addr_in[0]) || (word && (bus.addr_in[1:0] != 2'b00));
    strb  = 4'b0000;
    wdat  = '0;
    case (bus.store_flag_in)
      STORE_B: begin
        strb = 4'b0001 << bus.addr_in[1:0];
        wdat = {4{bus.store_data_in[7:0]}};
      end
      STORE_H: begin
        strb = 4'b0011 << bus.addr_in[1:0];
        wdat = {2{bus.store_data_in[15:0]}};
      end
      STORE_W: begin
        strb = 4'b1111;
        wdat = bus.store_data_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= LSU_IDLE;
      cnt               <= '0;
      ld_q              <= 1'b0;
      ld_flag_q         <= NO_LOAD;
      off_q             <= 2'b00;
      rd_en_q           <= 1'b0;
      rd_addr_q         <= '0;
      bus.mem_req       <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wstrb     <= 4'b0000;
      bus.mem_wdata     <= '0;
      bus.wb_valid      <= 1'b0;
      bus.wb_en         <= 1'b0;
      bus.wb_addr       <= '0;
      bus.wb_data       <= '0;
      bus.misalign      <= 1'b0;
      bus.misalign_addr <= '0;
      bus.bus_err       <= 1'b0;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.misalign <= 1'b0;
      bus.bus_err  <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (bus.in_valid) begin
            if (!(is_ld || is_st)) begin
              bus.wb_valid <= 1'b1;
              bus.wb_data  <= bus.addr_in;
              bus.wb_addr  <= bus.rd_addr_in;
              bus.wb_en    <= bus.rd_en_in && (bus.rd_addr_in != '0);
            end else if (mis) begin
              bus.misalign      <= 1'b1;
              bus.misalign_addr <= bus.addr_in;
            end else begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= is_st;
              bus.mem_addr  <= {bus.addr_in[XLEN-1:2], 2'b00};
              bus.mem_wstrb <= is_st ? strb : 4'b0000;
              bus.mem_wdata <= is_st ? wdat : '0;
              ld_q          <= is_ld;
              ld_flag_q     <= is_ld ? bus.load_flag_in : NO_LOAD;
              off_q         <= bus.addr_in[1:0];
              rd_en_q       <= bus.rd_en_in;
              rd_addr_q     <= bus.rd_addr_in;
              cnt           <= '0;
              state         <= LSU_BUSY;
            end
          end
        end
        LSU_BUSY: begin
          // completion is checked first so it wins over a coincident timeout
          if (bus.mem_ready) begin
            bus.mem_req  <= 1'b0;
            bus.wb_valid <= 1'b1;
            bus.wb_addr  <= rd_addr_q;
            bus.wb_en    <= ld_q && rd_en_q && (rd_addr_q != '0);
            bus.wb_data  <= ld_q ? ld_data : '0;
            state        <= LSU_IDLE;
          end else if (cnt == TO_LAST) begin
            bus.mem_req <= 1'b0;
            bus.bus_err <= 1'b1;
            state       <= LSU_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table for single transfers plus hand-written
// wait-state, timeout and reset-mid-request sequences.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lsu_if bus();

  lsu #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  lf;
    logic [3:0]  sf;
    logic [31:0] sd;
    logic        rd_en;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        mem;
    logic        mis;
    logic [31:0] maddr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        wb_en;
    logic [31:0] wb_data;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.addr_in       = '0;
    bus.load_flag_in  = NO_LOAD;
    bus.store_flag_in = NO_STORE;
    bus.store_data_in = '0;
    bus.rd_en_in      = 1'b0;
    bus.rd_addr_in    = '0;
    bus.mem_ready     = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [4:0] lf, input logic [3:0] sf,
                       input logic [31:0] sd, input logic en, input logic [4:0] rd);
    bus.in_valid      = 1'b1;
    bus.addr_in       = a;
    bus.load_flag_in  = lf;
    bus.store_flag_in = sf;
    bus.store_data_in = sd;
    bus.rd_en_in      = en;
    bus.rd_addr_in    = rd;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, " mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, " mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
    chk({tag, " mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, " wb_valid"}, 32'(bus.wb_valid), 32'd0);
    chk({tag, " wb_en"}, 32'(bus.wb_en), 32'd0);
    chk({tag, " wb_addr"}, 32'(bus.wb_addr), 32'd0);
    chk({tag, " wb_data"}, bus.wb_data, 32'd0);
    chk({tag, " misalign"}, 32'(bus.misalign), 32'd0);
    chk({tag, " misalign_addr"}, bus.misalign_addr, 32'd0);
    chk({tag, " bus_err"}, 32'(bus.bus_err), 32'd0);
  endtask

  initial begin
    //          addr          lf       sf        sd            en  rd     rdata         mem  mis  maddr         we   strb     wdata         wb_en wb_data
    vecs[0]  = '{32'h0000_1234, NO_LOAD, NO_STORE, 32'h0,        1, 5'd5,  32'h0,        0,   0,   32'h0,        0,   4'b0000, 32'h0,        1,    32'h0000_1234};
    vecs[1]  = '{32'h0000_0042, NO_LOAD, NO_STORE, 32'h0,        1, 5'd0,  32'h0,        0,   0,   32'h0,        0,   4'b0000, 32'h0,        0,    32'h0000_0042};
    vecs[2]  = '{32'h0000_0103, LOAD_B,  NO_STORE, 32'h0,        1, 5'd3,  32'h80FF_0000, 1,  0,   32'h0000_0100, 0,   4'b0000, 32'h0,        1,    32'hFFFF_FF80};
    vecs[3]  = '{32'h0000_0103, LOAD_BU, NO_STORE, 32'h0,        1, 5'd3,  32'h80FF_0000, 1,  0,   32'h0000_0100, 0,   4'b0000, 32'h0,        1,    32'h0000_0080};
    vecs[4]  = '{32'h0000_0102, LOAD_H,  NO_STORE, 32'h0,        1, 5'd9,  32'h8001_1234, 1,  0,   32'h0000_0100, 0,   4'b0000, 32'h0,        1,    32'hFFFF_8001};
    vecs[5]  = '{32'h0000_0100, LOAD_HU, NO_STORE, 32'h0,        1, 5'd10, 32'h0000_F00D, 1,  0,   32'h0000_0100, 0,   4'b0000, 32'h0,        1,    32'h0000_F00D};
    vecs[6]  = '{32'h0000_0104, LOAD_W,  NO_STORE, 32'h0,        1, 5'd31, 32'hCAFE_BABE, 1,  0,   32'h0000_0104, 0,   4'b0000, 32'h0,        1,    32'hCAFE_BABE};
    vecs[7]  = '{32'h0000_0301, NO_LOAD, STORE_B,  32'h1122_3344, 1, 5'd7, 32'h0,        1,   0,   32'h0000_0300, 1,   4'b0010, 32'h4444_4444, 0,    32'h0};
    vecs[8]  = '{32'h0000_0400, NO_LOAD, STORE_W,  32'hA5A5_5A5A, 0, 5'd0, 32'h0,        1,   0,   32'h0000_0400, 1,   4'b1111, 32'hA5A5_5A5A, 0,    32'h0};
    vecs[9]  = '{32'h0000_0101, LOAD_W,  NO_STORE, 32'h0,        1, 5'd4,  32'h0,        0,   1,   32'h0,        0,   4'b0000, 32'h0,        0,    32'h0};
    vecs[10] = '{32'h0000_0103, LOAD_H,  NO_STORE, 32'h0,        1, 5'd4,  32'h0,        0,   1,   32'h0,        0,   4'b0000, 32'h0,        0,    32'h0};
    vecs[11] = '{32'h0000_0205, NO_LOAD, STORE_H,  32'h1234_5678, 0, 5'd0, 32'h0,        0,   1,   32'h0,        0,   4'b0000, 32'h0,        0,    32'h0};
    vecs[12] = '{32'h0000_0502, LOAD_HU, STORE_W,  32'h5555_5555, 1, 5'd12, 32'hBEEF_0000, 1, 0,   32'h0000_0500, 0,   4'b0000, 32'h0,        1,    32'h0000_BEEF};
    vecs[13] = '{32'h0000_0777, 5'b00011, NO_STORE, 32'h0,       1, 5'd2,  32'h0,        0,   0,   32'h0,        0,   4'b0000, 32'h0,        1,    32'h0000_0777};
    vecs[14] = '{32'h0000_0100, LOAD_B,  NO_STORE, 32'h0,        1, 5'd0,  32'h1234_567F, 1,  0,   32'h0000_0100, 0,   4'b0000, 32'h0,        0,    32'h0000_007F};

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk_reset_state("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].addr, vecs[i].lf, vecs[i].sf, vecs[i].sd, vecs[i].rd_en, vecs[i].rd);
      step();
      bus.in_valid = 1'b0;
      if (vecs[i].mem) begin
        chk($sformatf("v%0d mem_req", i), 32'(bus.mem_req), 32'd1);
        chk($sformatf("v%0d in_ready busy", i), 32'(bus.in_ready), 32'd0);
        chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].maddr);
        chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].we));
        chk($sformatf("v%0d mem_wstrb", i), 32'(bus.mem_wstrb), 32'(vecs[i].strb));
        if (vecs[i].we) chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].wdata);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = vecs[i].rdata;
        step();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        chk($sformatf("v%0d wb_valid", i), 32'(bus.wb_valid), 32'd1);
        chk($sformatf("v%0d in_ready done", i), 32'(bus.in_ready), 32'd1);
        chk($sformatf("v%0d wb_en", i), 32'(bus.wb_en), 32'(vecs[i].wb_en));
        chk($sformatf("v%0d wb_addr", i), 32'(bus.wb_addr), 32'(vecs[i].rd));
        if (!vecs[i].we) chk($sformatf("v%0d wb_data", i), bus.wb_data, vecs[i].wb_data);
      end else if (vecs[i].mis) begin
        chk($sformatf("v%0d misalign", i), 32'(bus.misalign), 32'd1);
        chk($sformatf("v%0d misalign_addr", i), bus.misalign_addr, vecs[i].addr);
        chk($sformatf("v%0d wb_valid", i), 32'(bus.wb_valid), 32'd0);
        chk($sformatf("v%0d mem_req", i), 32'(bus.mem_req), 32'd0);
        chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'd1);
      end else begin
        chk($sformatf("v%0d wb_valid", i), 32'(bus.wb_valid), 32'd1);
        chk($sformatf("v%0d wb_data", i), bus.wb_data, vecs[i].wb_data);
        chk($sformatf("v%0d wb_en", i), 32'(bus.wb_en), 32'(vecs[i].wb_en));
        chk($sformatf("v%0d wb_addr", i), 32'(bus.wb_addr), 32'(vecs[i].rd));
        chk($sformatf("v%0d mem_req", i), 32'(bus.mem_req), 32'd0);
      end
      step();
      chk($sformatf("v%0d wb_valid pulse", i), 32'(bus.wb_valid), 32'd0);
      chk($sformatf("v%0d misalign pulse", i), 32'(bus.misalign), 32'd0);
      chk($sformatf("v%0d mem_req after", i), 32'(bus.mem_req), 32'd0);
    end

    // back-to-back plain results, one per cycle
    drive(32'h0000_0AAA, NO_LOAD, NO_STORE, 32'h0, 1'b1, 5'd1);
    step();
    chk("b2b first wb_data", bus.wb_data, 32'h0000_0AAA);
    chk("b2b first in_ready", 32'(bus.in_ready), 32'd1);
    drive(32'h0000_0BBB, NO_LOAD, NO_STORE, 32'h0, 1'b1, 5'd2);
    step();
    bus.in_valid = 1'b0;
    chk("b2b second wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("b2b second wb_data", bus.wb_data, 32'h0000_0BBB);
    chk("b2b second wb_addr", 32'(bus.wb_addr), 32'd2);
    step();

    // STORE_H with three wait cycles; ready lands as the counter hits its limit
    drive(32'h0000_0202, NO_LOAD, STORE_H, 32'hDEAD_BEEF, 1'b1, 5'd6);
    step();
    bus.in_valid = 1'b0;
    chk("sth mem_wstrb", 32'(bus.mem_wstrb), 32'h0000_000C);
    chk("sth mem_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
    chk("sth mem_addr", bus.mem_addr, 32'h0000_0200);
    for (int w = 0; w < 3; w++) begin
      step();
      chk($sformatf("sth wait%0d mem_req", w), 32'(bus.mem_req), 32'd1);
      chk($sformatf("sth wait%0d in_ready", w), 32'(bus.in_ready), 32'd0);
      chk($sformatf("sth wait%0d wstrb", w), 32'(bus.mem_wstrb), 32'h0000_000C);
      chk($sformatf("sth wait%0d wb_valid", w), 32'(bus.wb_valid), 32'd0);
    end
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("sth wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("sth wb_en", 32'(bus.wb_en), 32'd0);
    chk("sth bus_err", 32'(bus.bus_err), 32'd0);
    chk("sth in_ready", 32'(bus.in_ready), 32'd1);
    chk("sth mem_req", 32'(bus.mem_req), 32'd0);
    step();

    // LOAD_W that never completes: abort after four request cycles
    drive(32'h0000_0100, LOAD_W, NO_STORE, 32'h0, 1'b1, 5'd8);
    step();
    bus.in_valid = 1'b0;
    chk("to cyc0 mem_req", 32'(bus.mem_req), 32'd1);
    for (int w = 1; w < 4; w++) begin
      step();
      chk($sformatf("to cyc%0d mem_req", w), 32'(bus.mem_req), 32'd1);
      chk($sformatf("to cyc%0d bus_err", w), 32'(bus.bus_err), 32'd0);
    end
    step();
    chk("to bus_err", 32'(bus.bus_err), 32'd1);
    chk("to mem_req drop", 32'(bus.mem_req), 32'd0);
    chk("to in_ready", 32'(bus.in_ready), 32'd1);
    chk("to wb_valid", 32'(bus.wb_valid), 32'd0);
    step();
    chk("to bus_err pulse", 32'(bus.bus_err), 32'd0);
    chk("to wb_valid after", 32'(bus.wb_valid), 32'd0);

    // reset in the second BUSY cycle, stray mem_ready afterwards
    drive(32'h0000_0200, LOAD_W, NO_STORE, 32'h0, 1'b1, 5'd11);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("rst busy mem_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("mid-busy reset");
    step();
    step();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    step();
    bus.mem_ready = 1'b0;
    chk("stray ready wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("stray ready mem_req", 32'(bus.mem_req), 32'd0);
    chk("stray ready in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("stray ready wb_valid later", 32'(bus.wb_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
